pipe_hazard_ctrl: RTL and testbench



---
 rtl/pipe_hazard_ctrl_pkg.sv | 19 +
 rtl/pipe_hazard_ctrl_if.sv | 42 ++++
 rtl/pipe_hazard_ctrl_sat_counter.sv | 37 +++
 rtl/pipe_hazard_ctrl.sv | 131 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pipe_hazard_ctrl_pkg
// Brief   : Shared pipeline constants and FSM state encoding.
// Revision: 1.0
// ============================================================================
package pipe_hazard_ctrl_pkg;

    localparam int unsigned PHC_REG_W = 5;

    localparam logic [PHC_REG_W-1:0] PHC_ZERO_REG = '0;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

endpackage : pipe_hazard_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : pipe_hazard_ctrl_if
// Brief   : Pipeline <-> hazard controller signal bundle (hazard inputs, stage controls).
// Revision: 1.0
// ============================================================================
interface pipe_hazard_ctrl_if
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_W = PHC_REG_W
);
    logic [REG_W-1:0] id_rs_i;
    logic [REG_W-1:0] id_rt_i;
    logic             id_uses_rt_i;
    logic             ex_memread_i;
    logic [REG_W-1:0] ex_rd_i;
    logic             id_branch_taken_i;
    logic             id_jump_i;
    logic             mem_req_i;
    logic             mem_ack_i;

    logic             pc_write_o;
    logic             ifid_write_o;
    logic             ifid_flush_o;
    logic             idex_bubble_o;
    logic             exmem_hold_o;

    // Pipeline datapath side: reports hazard sources, consumes stage controls.
    modport master (
        output id_rs_i, id_rt_i, id_uses_rt_i, ex_memread_i, ex_rd_i,
        output id_branch_taken_i, id_jump_i, mem_req_i, mem_ack_i,
        input  pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, exmem_hold_o
    );

    modport slave (
        input  id_rs_i, id_rt_i, id_uses_rt_i, ex_memread_i, ex_rd_i,
        input  id_branch_taken_i, id_jump_i, mem_req_i, mem_ack_i,
        output pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, exmem_hold_o
    );

endinterface : pipe_hazard_ctrl_if
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module  : sat_counter
// Brief   : Up-counter that sticks at all-ones; asynchronous active-low clear.
// Revision: 1.0
// ============================================================================
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  wire logic             clk_i,
    input  wire logic             rst_n_i,
    input  wire logic             inc_i,
    output logic [WIDTH-1:0]      cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pipe_hazard_ctrl
// Brief   : 5-stage pipeline hazard/sequencing control with perf counters and watchdog.
// Revision: 1.0
// ============================================================================
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_W     = PHC_REG_W,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned STALL_MAX = 64
) (
    input  wire logic               clk_i,
    input  wire logic               rst_n_i,
    pipe_hazard_ctrl_if.slave       hz,
    output logic [CNT_W-1:0]        stall_cnt_o,
    output logic [CNT_W-1:0]        flush_cnt_o,
    output logic                    err_o
);

    localparam int unsigned        WD_W     = $clog2(STALL_MAX + 1);
    localparam logic [WD_W-1:0]    WD_LIMIT = WD_W'(STALL_MAX);
    localparam logic [REG_W-1:0]   ZERO_REG = REG_W'(PHC_ZERO_REG);

    state_e            state_q;
    state_e            state_d;
    logic [WD_W-1:0]   wd_q;
    logic [WD_W-1:0]   wd_d;
    logic              err_q;
    logic              err_d;

    logic              w_mem_stall;
    logic              w_load_use;
    logic              w_redirect;

    always_comb begin
        w_mem_stall = ((state_q == MEM_WAIT) && !hz.mem_ack_i) ||
                      ((state_q == RUN) && hz.mem_req_i && !hz.mem_ack_i);
        w_load_use  = hz.ex_memread_i && (hz.ex_rd_i != ZERO_REG) &&
                      ((hz.ex_rd_i == hz.id_rs_i) ||
                       (hz.id_uses_rt_i && (hz.ex_rd_i == hz.id_rt_i)));
        w_redirect  = hz.id_branch_taken_i || hz.id_jump_i;
    end

    // A load-use stall must also mask redirect: the branch compared a stale operand.
    always_comb begin
        hz.pc_write_o    = 1'b1;
        hz.ifid_write_o  = 1'b1;
        hz.ifid_flush_o  = 1'b0;
        hz.idex_bubble_o = 1'b0;
        hz.exmem_hold_o  = 1'b0;
        if (!rst_n_i) begin
            hz.pc_write_o    = 1'b0;
            hz.ifid_write_o  = 1'b0;
            hz.ifid_flush_o  = 1'b1;
            hz.idex_bubble_o = 1'b1;
        end else if (w_mem_stall) begin
            hz.pc_write_o    = 1'b0;
            hz.ifid_write_o  = 1'b0;
            hz.exmem_hold_o  = 1'b1;
        end else if (w_load_use) begin
            hz.pc_write_o    = 1'b0;
            hz.ifid_write_o  = 1'b0;
            hz.idex_bubble_o = 1'b1;
        end else if (w_redirect) begin
            hz.ifid_write_o  = 1'b0;
            hz.ifid_flush_o  = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        case (state_q)
            RUN: begin
                wd_d = '0;
                if (hz.mem_req_i && !hz.mem_ack_i) begin
                    state_d = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (hz.mem_ack_i) begin
                    state_d = RUN;
                    wd_d    = '0;
                end else if (wd_q != WD_LIMIT) begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: begin
                state_d = RUN;
                wd_d    = '0;
            end
        endcase
        err_d = err_q || (wd_d == WD_LIMIT);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= RUN;
            wd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
        end
    end

    assign err_o = err_q;

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (w_mem_stall || w_load_use),
        .cnt_o   (stall_cnt_o)
    );

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_flush_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (hz.ifid_flush_o && rst_n_i),
        .cnt_o   (flush_cnt_o)
    );

endmodule : pipe_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipe_hazard_ctrl
// Brief   : Directed + random checks of pipe_hazard_ctrl against a behavioural model.
// Revision: 1.0
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int unsigned REG_W     = 5;
    localparam int unsigned CNT_W     = 5;
    localparam int unsigned STALL_MAX = 4;
    localparam int          CNT_SAT   = (1 << CNT_W) - 1;

    logic clk;
    logic rst_n;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic err;

    int total = 0;
    int bad   = 0;

    // Behavioural model: waiting-on-memory flag, wait length, sticky error, event counts.
    bit m_wait;
    int m_wd;
    bit m_err;
    int m_stall;
    int m_flush;
    bit e_pc, e_ifw, e_fl, e_bub, e_hold, e_stall_evt;

    pipe_hazard_ctrl_if #(.REG_W(REG_W)) bus ();

    pipe_hazard_ctrl #(
        .REG_W     (REG_W),
        .CNT_W     (CNT_W),
        .STALL_MAX (STALL_MAX)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .hz          (bus),
        .stall_cnt_o (stall_cnt),
        .flush_cnt_o (flush_cnt),
        .err_o       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_wait = 0; m_wd = 0; m_err = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic model_eval();
        bit ms, lu, rd;
        ms = m_wait ? !bus.mem_ack_i : (bus.mem_req_i && !bus.mem_ack_i);
        lu = bus.ex_memread_i && (bus.ex_rd_i != 0) &&
             ((bus.ex_rd_i == bus.id_rs_i) || (bus.id_uses_rt_i && bus.ex_rd_i == bus.id_rt_i));
        rd = bus.id_branch_taken_i || bus.id_jump_i;
        {e_pc, e_ifw, e_fl, e_bub, e_hold} = ms ? 5'b00001 :
                                             lu ? 5'b00010 :
                                             rd ? 5'b10100 : 5'b11000;
        e_stall_evt = ms || lu;
    endtask

    task automatic model_edge();
        model_eval();
        if (e_stall_evt && m_stall < CNT_SAT) m_stall++;
        if (e_fl && m_flush < CNT_SAT) m_flush++;
        if (m_wait) begin
            if (bus.mem_ack_i) begin
                m_wait = 0;
                m_wd   = 0;
            end else if (m_wd < STALL_MAX) begin
                m_wd++;
            end
        end else if (bus.mem_req_i && !bus.mem_ack_i) begin
            m_wait = 1;
        end
        if (m_wd >= STALL_MAX) m_err = 1;
    endtask

    task automatic idle_inputs();
        bus.id_rs_i = '0; bus.id_rt_i = '0; bus.id_uses_rt_i = 0;
        bus.ex_memread_i = 0; bus.ex_rd_i = '0;
        bus.id_branch_taken_i = 0; bus.id_jump_i = 0;
        bus.mem_req_i = 0; bus.mem_ack_i = 0;
    endtask

    // One clock: compare mid-cycle against the model, then advance both at the edge.
    task automatic cyc(input string tag);
        @(negedge clk);
        model_eval();
        chk({tag, ".pc_write"},    32'(bus.pc_write_o),    32'(e_pc));
        chk({tag, ".ifid_write"},  32'(bus.ifid_write_o),  32'(e_ifw));
        chk({tag, ".ifid_flush"},  32'(bus.ifid_flush_o),  32'(e_fl));
        chk({tag, ".idex_bubble"}, 32'(bus.idex_bubble_o), 32'(e_bub));
        chk({tag, ".exmem_hold"},  32'(bus.exmem_hold_o),  32'(e_hold));
        chk({tag, ".stall_cnt"},   32'(stall_cnt),         32'(m_stall));
        chk({tag, ".flush_cnt"},   32'(flush_cnt),         32'(m_flush));
        chk({tag, ".err"},         32'(err),               32'(m_err));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        int snap;
        rst_n = 1'b0;
        idle_inputs();
        model_reset();

        // Reset values
        @(negedge clk);
        chk("rst.pc_write",    32'(bus.pc_write_o),    0);
        chk("rst.ifid_write",  32'(bus.ifid_write_o),  0);
        chk("rst.ifid_flush",  32'(bus.ifid_flush_o),  1);
        chk("rst.idex_bubble", 32'(bus.idex_bubble_o), 1);
        chk("rst.exmem_hold",  32'(bus.exmem_hold_o),  0);
        chk("rst.counters",    32'({stall_cnt, flush_cnt, err}), 0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        cyc("idle0");
        cyc("idle1");

        // Load-use via rs, then register 0 never hazards
        bus.ex_memread_i = 1; bus.ex_rd_i = 8; bus.id_rs_i = 8;
        cyc("lu_rs");
        chk("lu_rs.stall_cnt1", 32'(stall_cnt), 1);
        bus.ex_rd_i = 0; bus.id_rs_i = 0;
        cyc("lu_r0");
        chk("lu_r0.stall_cnt1", 32'(stall_cnt), 1);
        // rt path only counts when rt is actually read
        bus.ex_rd_i = 9; bus.id_rs_i = 3; bus.id_rt_i = 9; bus.id_uses_rt_i = 1;
        cyc("lu_rt");
        bus.id_uses_rt_i = 0;
        cyc("lu_rt_unused");
        idle_inputs();

        // Taken branch, jump, then branch masked by load-use
        bus.id_branch_taken_i = 1;
        cyc("branch");
        chk("branch.flush_cnt1", 32'(flush_cnt), 1);
        bus.id_branch_taken_i = 0; bus.id_jump_i = 1;
        cyc("jump");
        bus.id_jump_i = 0; bus.id_branch_taken_i = 1;
        bus.ex_memread_i = 1; bus.ex_rd_i = 12; bus.id_rs_i = 12;
        cyc("branch_lu");
        chk("branch_lu.flush_cnt2", 32'(flush_cnt), 2);
        idle_inputs();

        // Memory stall: 3 frozen cycles then ack, with hazards present during the freeze
        snap = m_stall;
        bus.mem_req_i = 1; bus.mem_ack_i = 0;
        bus.id_branch_taken_i = 1;
        cyc("mem_w0");
        cyc("mem_w1");
        cyc("mem_w2");
        bus.mem_ack_i = 1;
        cyc("mem_ack");
        chk("mem.stall_delta3", 32'(stall_cnt), 32'(snap + 3));
        bus.id_branch_taken_i = 0;
        snap = m_stall;
        cyc("mem_same_ack");
        chk("mem.same_ack_no_stall", 32'(stall_cnt), 32'(snap));
        idle_inputs();
        cyc("mem_idle");

        // Watchdog: 6 cycles without ack
        bus.mem_req_i = 1; bus.mem_ack_i = 0;
        cyc("wd_enter");
        for (int i = 0; i < 3; i++) cyc("wd_wait");
        chk("wd.err_before_4th", 32'(err), 0);
        cyc("wd_wait4");
        chk("wd.err_after_4th", 32'(err), 1);
        cyc("wd_wait5");
        bus.mem_ack_i = 1;
        cyc("wd_ack");
        bus.mem_ack_i = 0; bus.mem_req_i = 0;
        cyc("wd_after");
        chk("wd.err_sticky", 32'(err), 1);

        // Async reset in the middle of MEM_WAIT
        bus.mem_req_i = 1;
        cyc("ar_enter");
        cyc("ar_wait");
        #2 rst_n = 1'b0;
        #1;
        chk("ar.err_clear",   32'(err),       0);
        chk("ar.stall_clear", 32'(stall_cnt), 0);
        chk("ar.flush_clear", 32'(flush_cnt), 0);
        chk("ar.bubble",      32'(bus.idex_bubble_o), 1);
        model_reset();
        bus.mem_req_i = 0;
        #3 rst_n = 1'b1;
        #1;
        chk("ar.run_pc_write", 32'(bus.pc_write_o),   1);
        chk("ar.run_no_hold",  32'(bus.exmem_hold_o), 0);
        @(posedge clk); #1;
        cyc("ar_idle");

        // Counter saturation
        bus.ex_memread_i = 1; bus.ex_rd_i = 5; bus.id_rs_i = 5;
        for (int i = 0; i < CNT_SAT + 4; i++) cyc("sat_stall");
        chk("sat.stall_allones", 32'(stall_cnt), 32'(CNT_SAT));
        idle_inputs();
        bus.id_jump_i = 1;
        for (int i = 0; i < CNT_SAT + 4; i++) cyc("sat_flush");
        chk("sat.flush_allones", 32'(flush_cnt), 32'(CNT_SAT));
        idle_inputs();

        // Random traffic from a fresh reset so the counters have room to move
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 300; i++) begin
            bus.id_rs_i           = REG_W'($urandom_range(0, 3));
            bus.id_rt_i           = REG_W'($urandom_range(0, 3));
            bus.ex_rd_i           = REG_W'($urandom_range(0, 3));
            bus.id_uses_rt_i      = 1'($urandom_range(0, 1));
            bus.ex_memread_i      = 1'($urandom_range(0, 1));
            bus.id_branch_taken_i = ($urandom_range(0, 3) == 0);
            bus.id_jump_i         = ($urandom_range(0, 5) == 0);
            bus.mem_req_i         = ($urandom_range(0, 2) == 0);
            bus.mem_ack_i         = ($urandom_range(0, 2) != 0);
            cyc("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pipe_hazard_ctrl
`default_nettype wire
